// File: rtl/water_tank_level_encoder.sv
// Three-probe water-tank level encoder: per-probe two-flop sync and debounce, then a
// thermometer-code check feeding a small FSM that registers level, valid, change and fault.
module water_tank_level_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_WIDTH       = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] probe_raw,
  output logic [1:0] tank_level_status,
  output logic       level_valid,
  output logic       level_changed,
  output logic       sensor_fault
);

  // INIT waits until the probe values present at reset release have had time to
  // pass through the synchroniser and a full debounce window before trusting deb.
  localparam int unsigned SETTLE_CYCLES = DEBOUNCE_CYCLES + 2;
  localparam int unsigned SETTLE_WIDTH  = $clog2(SETTLE_CYCLES + 1);

  localparam logic [CNT_WIDTH-1:0]    CNT_LAST    = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [SETTLE_WIDTH-1:0] SETTLE_LAST = SETTLE_WIDTH'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    S_INIT,
    S_TRACK,
    S_FAULT
  } state_e;

  logic [2:0]                meta_q, sync_q;
  logic [2:0]                deb_q, deb_d;
  logic [2:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [SETTLE_WIDTH-1:0]   settle_q, settle_d;
  state_e                    state_q, state_d;
  logic [1:0]                level_q, level_d;
  logic                      valid_q, valid_d;
  logic                      changed_q, changed_d;
  logic                      fault_q, fault_d;

  logic                      code_ok;
  logic [1:0]                code_level;

  // NOTE: every always_comb variable gets a default first, so no path can infer a latch.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    code_ok    = 1'b1;
    code_level = 2'b00;
    case (deb_q)
      3'b000:  code_level = 2'b00;
      3'b001:  code_level = 2'b01;
      3'b011:  code_level = 2'b10;
      3'b111:  code_level = 2'b11;
      default: code_ok    = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    level_d   = level_q;
    valid_d   = valid_q;
    changed_d = 1'b0;
    fault_d   = fault_q;
    case (state_q)
      S_INIT: begin
        if (settle_q != SETTLE_LAST) begin
          settle_d = settle_q + SETTLE_WIDTH'(1);
        end else if (code_ok) begin
          level_d = code_level;
          valid_d = 1'b1;
          state_d = S_TRACK;
        end else begin
          fault_d = 1'b1;
          state_d = S_FAULT;
        end
      end
      S_TRACK: begin
        if (!code_ok) begin
          fault_d = 1'b1;
          state_d = S_FAULT;
        end else if (code_level != level_q) begin
          level_d   = code_level;
          changed_d = 1'b1;
        end
      end
      S_FAULT: begin
        if (code_ok) begin
          fault_d   = 1'b0;
          state_d   = S_TRACK;
          level_d   = code_level;
          valid_d   = 1'b1;
          // A first level acquired out of FAULT is a load, not a change.
          changed_d = valid_q && (code_level != level_q);
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q    <= '0;
      sync_q    <= '0;
      deb_q     <= '0;
      cnt_q     <= '0;
      settle_q  <= '0;
      state_q   <= S_INIT;
      level_q   <= 2'b00;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      meta_q    <= probe_raw;
      sync_q    <= meta_q;
      deb_q     <= deb_d;
      cnt_q     <= cnt_d;
      settle_q  <= settle_d;
      state_q   <= state_d;
      level_q   <= level_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
      fault_q   <= fault_d;
    end
  end

  assign tank_level_status = level_q;
  assign level_valid       = valid_q;
  assign level_changed     = changed_q;
  assign sensor_fault      = fault_q;

endmodule

// File: tb/tb_water_tank_level_encoder.sv
// Bench for water_tank_level_encoder with DEBOUNCE_CYCLES=4: directed scenarios plus a
// randomized run against a sample-window reference model of sync, debounce and level logic.
module tb_water_tank_level_encoder;

  localparam int D = 4;

  logic       clk;
  logic       reset_n;
  logic [2:0] probe_raw;
  logic [1:0] tank_level_status;
  logic       level_valid;
  logic       level_changed;
  logic       sensor_fault;
  logic [4:0] obs;

  int total;
  int bad;

  water_tank_level_encoder #(
    .DEBOUNCE_CYCLES(D),
    .CNT_WIDTH      (3)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .probe_raw        (probe_raw),
    .tank_level_status(tank_level_status),
    .level_valid      (level_valid),
    .level_changed    (level_changed),
    .sensor_fault     (sensor_fault)
  );

  assign obs = {tank_level_status, level_valid, level_changed, sensor_fault};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: probe_sync is raw delayed two edges; a debounced bit flips once the
  // last D samples of probe_sync all disagree with it; level = number of wet probes.
  logic [2:0] m_s1, m_s2, m_deb;
  logic [2:0] hist[$];
  int         m_edges;
  logic [1:0] m_level;
  logic       m_valid, m_changed, m_fault;

  function automatic logic [4:0] exp_of(input logic [1:0] lvl, input logic v,
                                        input logic c, input logic f);
    return {lvl, v, c, f};
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_deb = '0; hist.delete();
    m_edges = 0; m_level = '0; m_valid = 0; m_changed = 0; m_fault = 0;
  endtask

  task automatic model_edge(input logic [2:0] raw);
    logic [2:0] new_deb;
    bit         ok, all_diff;
    int         lvl;
    m_edges++;
    m_changed = 1'b0;
    if (m_edges >= D + 3) begin
      ok = (m_deb == 3'b000) || (m_deb == 3'b001) || (m_deb == 3'b011) || (m_deb == 3'b111);
      if (ok) begin
        lvl       = $countones(m_deb);
        m_changed = m_valid && (lvl != int'(m_level));
        m_level   = 2'(lvl);
        m_valid   = 1'b1;
        m_fault   = 1'b0;
      end else begin
        m_fault = 1'b1;
      end
    end
    hist.push_back(m_s2);
    if (hist.size() > D) void'(hist.pop_front());
    new_deb = m_deb;
    if (hist.size() == D) begin
      for (int b = 0; b < 3; b++) begin
        all_diff = 1;
        foreach (hist[j]) if (hist[j][b] == m_deb[b]) all_diff = 0;
        if (all_diff) new_deb[b] = ~m_deb[b];
      end
    end
    m_deb = new_deb;
    m_s2  = m_s1;
    m_s1  = raw;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      logic [2:0] r;
      r = probe_raw;
      @(posedge clk);
      #1;
      model_edge(r);
    end
  endtask

  task automatic test_reset(input logic [2:0] raw);
    @(posedge clk);
    #1;
    reset_n   = 1'b0;
    probe_raw = raw;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs !== 5'b0) begin
      bad++;
      $display("FAIL reset_state: got %b want %b", obs, 5'b0);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_power_up();
    logic [4:0] e;
    test_reset(3'b000);
    for (int i = 1; i <= 8; i++) begin
      step(1);
      e = (i >= 7) ? exp_of(2'b00, 1, 0, 0) : 5'b0;
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL power_up edge %0d: got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_fill();
    logic [2:0] pat[3];
    logic [4:0] e;
    pat[0] = 3'b001; pat[1] = 3'b011; pat[2] = 3'b111;
    for (int p = 0; p < 3; p++) begin
      probe_raw = pat[p];
      for (int i = 1; i <= 8; i++) begin
        step(1);
        if (i < 7)       e = exp_of(2'(p), 1, 0, 0);
        else if (i == 7) e = exp_of(2'(p + 1), 1, 1, 0);
        else             e = exp_of(2'(p + 1), 1, 0, 0);
        total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL fill level %0d edge %0d: got %b want %b", p + 1, i, obs, e);
        end
      end
    end
  endtask

  task automatic test_glitch();
    logic [4:0] e;
    probe_raw = 3'b001;
    step(10);
    for (int i = 1; i <= 14; i++) begin
      probe_raw = (i <= 3) ? 3'b011 : 3'b001;
      step(1);
      e = exp_of(2'b01, 1, 0, 0);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL glitch_3cyc edge %0d: got %b want %b", i, obs, e);
      end
    end
    for (int i = 1; i <= 12; i++) begin
      probe_raw = (i <= 4) ? 3'b011 : 3'b001;
      step(1);
      if (i < 7)       e = exp_of(2'b01, 1, 0, 0);
      else if (i == 7) e = exp_of(2'b10, 1, 1, 0);
      else if (i < 11) e = exp_of(2'b10, 1, 0, 0);
      else if (i == 11) e = exp_of(2'b01, 1, 1, 0);
      else             e = exp_of(2'b01, 1, 0, 0);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL glitch_4cyc edge %0d: got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_fault();
    logic [4:0] e;
    probe_raw = 3'b011;
    step(8);
    total++;
    if (obs !== exp_of(2'b10, 1, 0, 0)) begin
      bad++;
      $display("FAIL fault_setup: got %b want %b", obs, exp_of(2'b10, 1, 0, 0));
    end
    probe_raw = 3'b101;
    for (int i = 1; i <= 9; i++) begin
      step(1);
      e = exp_of(2'b10, 1, 0, (i >= 7));
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL fault_enter edge %0d: got %b want %b", i, obs, e);
      end
    end
    probe_raw = 3'b011;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      e = exp_of(2'b10, 1, 0, (i < 7));
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL fault_exit edge %0d: got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_reset_invalid();
    logic [4:0] e;
    test_reset(3'b110);
    for (int i = 1; i <= 8; i++) begin
      step(1);
      e = (i >= 7) ? exp_of(2'b00, 0, 0, 1) : 5'b0;
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL reset_invalid edge %0d: got %b want %b", i, obs, e);
      end
    end
    probe_raw = 3'b111;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      e = (i >= 7) ? exp_of(2'b11, 1, 0, 0) : exp_of(2'b00, 0, 0, 1);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL invalid_recover edge %0d: got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] e;
    probe_raw = 3'b000;
    step(4);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (obs !== 5'b0) begin
      bad++;
      $display("FAIL async_reset: got %b want %b", obs, 5'b0);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n   = 1'b1;
    probe_raw = 3'b011;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      e = (i >= 7) ? exp_of(2'b10, 1, 0, 0) : 5'b0;
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL reacquire edge %0d: got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] therm[4];
    logic [4:0] e;
    int         hold;
    therm[0] = 3'b000; therm[1] = 3'b001; therm[2] = 3'b011; therm[3] = 3'b111;
    test_reset(3'($urandom));
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 9) < 7) probe_raw = therm[$urandom_range(0, 3)];
      else                          probe_raw = 3'($urandom);
      hold = (n % 3 == 0) ? $urandom_range(1, 4) : $urandom_range(4, 10);
      for (int k = 0; k < hold; k++) begin
        step(1);
        e = exp_of(m_level, m_valid, m_changed, m_fault);
        total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL random seq %0d edge %0d raw %b: got %b want %b", n, k, probe_raw, obs, e);
        end
      end
      if ($urandom_range(0, 39) == 0) begin
        #2;
        reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    total     = 0;
    bad       = 0;
    reset_n   = 1'b0;
    probe_raw = 3'b000;
    model_reset();
    test_power_up();
    test_fill();
    test_glitch();
    test_fault();
    test_reset_invalid();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
